// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor.
// The requester drives start/operands; the engine drives results and status.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, borrow_in,
        input  diff, borrow, overflow, zero, busy, done
    );

    modport slave (
        input  start, a, b, borrow_in,
        output diff, borrow, overflow, zero, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per cycle,
// LSB slice first, with the borrow registered between slices.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] work_next;

    // One slice of the borrow chain, and the working result with it shifted in at the top.
    always_comb begin
        slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};
        work_next = (work_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // FSM next state, operand capture, slice stepping and result load.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        work_d     = work_q;
        br_d       = br_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        cnt_d      = cnt_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    br_d    = bus.borrow_in;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                br_d   = slice[DIGIT];
                work_d = work_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Overflow uses the captured sign bits; the shift registers are spent.
                    diff_d     = work_next;
                    borrow_d   = slice[DIGIT];
                    overflow_d = (a_msb_q ^ b_msb_q) & (work_next[WIDTH-1] ^ a_msb_q);
                    zero_d     = (work_next == '0);
                    state_d    = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation and clears the results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            br_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            cnt_q      <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            work_q     <= work_d;
            br_q       <= br_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            cnt_q      <= cnt_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a DIGIT=1 and a DIGIT=4 instance, both WIDTH=8,
// checked every cycle against an arithmetic reference plus literal expectations.
module tb_serial_subtractor;
    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       overflow;
        logic       zero;
    } res_t;

    localparam int PIdle = 0;
    localparam int PRun  = 1;
    localparam int PDone = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic       bin_s   [2];
    logic [7:0] diff_w  [2];
    logic       borrow_w[2];
    logic       ovf_w   [2];
    logic       zero_w  [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int   n_checks;
    int   n_errors;
    bit   chk_on;

    int   m_phase[2];
    int   m_left [2];
    res_t m_pend [2];
    res_t m_out  [2];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if1 ();
    serial_subtractor_if #(.WIDTH(8)) if4 ();

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4));

    assign if1.start     = start_s[0];
    assign if1.a         = a_s[0];
    assign if1.b         = b_s[0];
    assign if1.borrow_in = bin_s[0];
    assign if4.start     = start_s[1];
    assign if4.a         = a_s[1];
    assign if4.b         = b_s[1];
    assign if4.borrow_in = bin_s[1];

    assign diff_w[0]   = if1.diff;
    assign borrow_w[0] = if1.borrow;
    assign ovf_w[0]    = if1.overflow;
    assign zero_w[0]   = if1.zero;
    assign busy_w[0]   = if1.busy;
    assign done_w[0]   = if1.done;
    assign diff_w[1]   = if4.diff;
    assign borrow_w[1] = if4.borrow;
    assign ovf_w[1]    = if4.overflow;
    assign zero_w[1]   = if4.zero;
    assign busy_w[1]   = if4.busy;
    assign done_w[1]   = if4.done;

    function automatic int n_of(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    // Plain integer arithmetic: unsigned for diff/borrow, signed range for overflow.
    function automatic res_t ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   u;
        int   s;
        res_t r;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.diff     = 8'(u);
        r.borrow   = (u < 0);
        r.overflow = (s < -128) || (s > 127);
        r.zero     = (8'(u) == 8'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference: operation accepted when idle/done, results appear N edges later.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= PIdle;
                m_left[k]  <= 0;
                m_out[k]   <= '0;
            end else if (m_phase[k] == PRun) begin
                if (m_left[k] == 1) begin
                    m_out[k]   <= m_pend[k];
                    m_phase[k] <= PDone;
                end
                m_left[k] <= m_left[k] - 1;
            end else if (start_s[k]) begin
                m_pend[k]  <= ref_sub(a_s[k], b_s[k], bin_s[k]);
                m_left[k]  <= n_of(k);
                m_phase[k] <= PRun;
            end else begin
                m_phase[k] <= PIdle;
            end
        end
    end

    // Cycle-by-cycle comparison, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, busy_w[k], m_phase[k] == PRun);
                chk("done", k, done_w[k], m_phase[k] == PDone);
                chk("busy_and_done", k, busy_w[k] & done_w[k], 0);
                chk("diff", k, diff_w[k], m_out[k].diff);
                chk("borrow", k, borrow_w[k], m_out[k].borrow);
                chk("overflow", k, ovf_w[k], m_out[k].overflow);
                chk("zero", k, zero_w[k], m_out[k].zero);
            end
        end
    end

    // Starts an operation at the current negedge; returns at the negedge showing done.
    task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input int inject, input logic [7:0] ed, input logic eb, input logic eo,
                      input logic ez);
        int cyc;
        int guard;
        cyc   = 0;
        guard = 0;
        start_s[k] = 1'b1;
        a_s[k]     = a;
        b_s[k]     = b;
        bin_s[k]   = bin;
        @(negedge clk);
        start_s[k] = 1'b0;
        while (!done_w[k] && guard < 40) begin
            if (busy_w[k]) cyc++;
            if (inject != 0 && cyc == inject) begin
                start_s[k] = 1'b1;
                a_s[k]     = ~a;
                b_s[k]     = a;
                bin_s[k]   = ~bin;
            end else begin
                start_s[k] = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        start_s[k] = 1'b0;
        chk("done_seen", k, done_w[k], 1);
        chk("busy_cycles", k, cyc, n_of(k));
        chk("lit_diff", k, diff_w[k], ed);
        chk("lit_borrow", k, borrow_w[k], eb);
        chk("lit_overflow", k, ovf_w[k], eo);
        chk("lit_zero", k, zero_w[k], ez);
    endtask

    task automatic settle(input int k);
        @(negedge clk);
        chk("done_single_pulse", k, done_w[k], 0);
        chk("idle_not_busy", k, busy_w[k], 0);
    endtask

    initial begin
        bit saw_done;
        n_checks = 0;
        n_errors = 0;
        chk_on   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            a_s[k]     = 8'h00;
            b_s[k]     = 8'h00;
            bin_s[k]   = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_diff", k, diff_w[k], 0);
            chk("reset_borrow", k, borrow_w[k], 0);
            chk("reset_overflow", k, ovf_w[k], 0);
            chk("reset_zero", k, zero_w[k], 0);
            chk("reset_busy", k, busy_w[k], 0);
            chk("reset_done", k, done_w[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        op(0, 8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0, 1'b0); settle(0);
        op(0, 8'h03, 8'h05, 1'b0, 0, 8'hFE, 1'b1, 1'b0, 1'b0); settle(0);
        op(0, 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1, 1'b0); settle(0);
        op(0, 8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1, 1'b0, 1'b0); settle(0);
        op(0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1); settle(0);

        // Second operation issued in the DONE cycle of the first.
        op(1, 8'h3C, 8'h1F, 1'b0, 0, 8'h1D, 1'b0, 1'b0, 1'b0);
        op(1, 8'h10, 8'h20, 1'b0, 0, 8'hF0, 1'b1, 1'b0, 1'b0); settle(1);

        // start and operand changes during RUN must be ignored.
        op(0, 8'h05, 8'h03, 1'b0, 3, 8'h02, 1'b0, 1'b0, 1'b0); settle(0);

        // Reset in the middle of a run: immediate clear, no done afterwards.
        start_s[0] = 1'b1;
        a_s[0]     = 8'h77;
        b_s[0]     = 8'h11;
        bin_s[0]   = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy", 0, busy_w[0], 1);
        rst = 1'b1;
        #1;
        chk("async_rst_diff", 0, diff_w[0], 0);
        chk("async_rst_busy", 0, busy_w[0], 0);
        chk("async_rst_done", 0, done_w[0], 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0]) saw_done = 1'b1;
        end
        chk("no_done_after_rst", 0, saw_done, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                start_s[k] = ($urandom_range(0, 2) == 0);
                a_s[k]     = 8'($urandom);
                b_s[k]     = ($urandom_range(0, 7) == 0) ? a_s[k] : 8'($urandom);
                bin_s[k]   = 1'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) start_s[k] = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
